// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
// funct3 values, data_mem size/sign mask fields and the LSU state type.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] MASK_BYTE = 3'b001;
  localparam logic [2:0] MASK_HALF = 3'b011;
  localparam logic [2:0] MASK_WORD = 3'b111;
  localparam int         SIGN_BIT  = 3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_size_decode.sv
// Combinational decode of a load/store into data_mem size/sign mask plus
// misalignment and illegal-funct3 flags. Zero latency, no flow control.
module lsu_size_decode
  import lsu_pkg::*;
(
  input  logic       write_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] sign_mask_o,
  output logic       misaligned_o,
  output logic       illegal_o
);

  always_comb begin
    sign_mask_o  = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      F3_B:  sign_mask_o[2:0] = MASK_BYTE;
      F3_H: begin
        sign_mask_o[2:0] = MASK_HALF;
        misaligned_o     = addr_lo_i[0];
      end
      F3_W: begin
        sign_mask_o[2:0] = MASK_WORD;
        misaligned_o     = |addr_lo_i;
      end
      F3_BU: begin
        sign_mask_o[2:0] = MASK_BYTE;
        illegal_o        = write_i;
      end
      F3_HU: begin
        sign_mask_o[2:0] = MASK_HALF;
        misaligned_o     = addr_lo_i[0];
        illegal_o        = write_i;
      end
      default: illegal_o = 1'b1;
    endcase
    // Sign extension is done by the memory, only for signed sub-word loads.
    sign_mask_o[SIGN_BIT] = !write_i && (funct3_i == F3_B || funct3_i == F3_H);
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store initiator for data_mem: captures one request, checks it, then runs
// the memory read/write/stall protocol and returns a single response pulse.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int STALL_TIMEOUT = 16,
  parameter int READ_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_stall
);

  localparam logic [4:0] READ_LAST   = 5'(READ_LAT - 1);
  localparam logic [4:0] TIMEOUT_CNT = 5'(STALL_TIMEOUT);

  lsu_state_e  state_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  cnt_q, cnt_d;
  logic        seen_stall_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        mem_memread_q, mem_memwrite_q;
  logic [3:0]  mem_mask_q;

  logic [3:0]  dec_mask;
  logic        dec_misaligned, dec_illegal;

  lsu_size_decode u_size_decode (
    .write_i      (write_q),
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_q[1:0]),
    .sign_mask_o  (dec_mask),
    .misaligned_o (dec_misaligned),
    .illegal_o    (dec_illegal)
  );

  assign cnt_d = (cnt_q == 5'h1f) ? cnt_q : cnt_q + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      funct3_q       <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      seen_stall_q   <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_mask_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          if (dec_misaligned || dec_illegal) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= RESP;
          end else begin
            mem_addr_q     <= addr_q;
            mem_wdata_q    <= wdata_q;
            mem_mask_q     <= dec_mask;
            mem_memwrite_q <= write_q;
            mem_memread_q  <= !write_q;
            cnt_q          <= '0;
            seen_stall_q   <= 1'b0;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          // The memory re-triggers on a held write, so it is a one-cycle pulse.
          mem_memwrite_q <= 1'b0;
          state_q        <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (!write_q) begin
            if (cnt_q == READ_LAST) begin
              resp_valid_q  <= 1'b1;
              resp_err_q    <= 1'b0;
              resp_rdata_q  <= mem_read_data;
              mem_memread_q <= 1'b0;
              state_q       <= RESP;
            end
          end else begin
            if (mem_stall) seen_stall_q <= 1'b1;
            if (seen_stall_q && !mem_stall) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= '0;
              state_q      <= RESP;
            end else if (cnt_d == TIMEOUT_CNT) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= RESP;
            end
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign mem_sign_mask  = mem_mask_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a byte-array data memory model that
// sign-extends per sign_mask and raises clk_stall for one cycle after a write.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memread, mem_memwrite, mem_stall;
  logic [3:0]  mem_sign_mask;

  logic        preload;
  logic        stall_en;
  logic [7:0]  mem_b [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_stall      (mem_stall)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a32, input logic [3:0] m);
    logic [7:0]  a;
    logic [15:0] h;
    logic [31:0] v;
    a = a32[7:0];
    h = {mem_b[a + 8'd1], mem_b[a]};
    case (m[2:0])
      3'b001:  v = {{24{m[3] & mem_b[a][7]}}, mem_b[a]};
      3'b011:  v = {{16{m[3] & h[15]}}, h};
      default: v = {mem_b[a + 8'd3], mem_b[a + 8'd2], h};
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    mem_stall <= 1'b0;
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
      mem_b[8'h10] <= 8'hEF; mem_b[8'h11] <= 8'hBE;
      mem_b[8'h12] <= 8'hAD; mem_b[8'h13] <= 8'hDE;
      mem_b[8'h20] <= 8'h78; mem_b[8'h21] <= 8'h56;
      mem_read_data <= '0;
    end else begin
      if (mem_memwrite) begin
        mem_b[mem_addr[7:0]] <= mem_write_data[7:0];
        if (mem_sign_mask[1]) mem_b[mem_addr[7:0] + 8'd1] <= mem_write_data[15:8];
        if (mem_sign_mask[2]) begin
          mem_b[mem_addr[7:0] + 8'd2] <= mem_write_data[23:16];
          mem_b[mem_addr[7:0] + 8'd3] <= mem_write_data[31:24];
        end
        if (stall_en) mem_stall <= 1'b1;
      end
      if (mem_memread) mem_read_data <= mem_rd(mem_addr, mem_sign_mask);
    end
  end

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        act;
    logic        err;
    logic [3:0]  mask;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  vec_t v_to, v_ld30;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string nm);
    int          guard;
    int          lat;
    int          wcnt;
    logic        act;
    logic [3:0]  m;
    logic [31:0] a, wd, rd;
    logic        err, rdy_resp;
    guard = 0; lat = -1; wcnt = 0; act = 1'b0; m = '0; a = '0; wd = '0; rd = '0;
    err = 1'b0; rdy_resp = 1'b1;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_ready_before"}, 32'(req_ready), 32'd1);
    req_write = v.write; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_memread || mem_memwrite) begin
        act = 1'b1; m = mem_sign_mask; a = mem_addr;
      end
      if (mem_memwrite) begin
        wcnt++; wd = mem_write_data;
      end
      if (resp_valid) begin
        lat = k; err = resp_err; rd = resp_rdata; rdy_resp = req_ready;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(v.lat));
    chk({nm, "_err"}, 32'(err), 32'(v.err));
    chk({nm, "_rdata"}, rd, v.rdata);
    chk({nm, "_mem_active"}, 32'(act), 32'(v.act));
    chk({nm, "_write_pulses"}, 32'(wcnt), 32'(v.act && v.write));
    if (v.act) begin
      chk({nm, "_mask"}, 32'(m), 32'(v.mask));
      chk({nm, "_addr"}, a, v.addr);
      if (v.write) chk({nm, "_wdata"}, wd, v.wdata);
    end
    chk({nm, "_ready_in_resp"}, 32'(rdy_resp), 32'd0);
    @(negedge clk);
    chk({nm, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int stray;
    vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 1'b0, 4'b0111, 32'hDEADBEEF, 4};
    vecs[1]  = '{1'b1, 3'b000, 32'h13, 32'hAAAAAA80, 1'b1, 1'b0, 4'b0001, 32'h0,        5};
    vecs[2]  = '{1'b0, 3'b000, 32'h13, 32'h0,        1'b1, 1'b0, 4'b1001, 32'hFFFFFF80, 4};
    vecs[3]  = '{1'b0, 3'b100, 32'h13, 32'h0,        1'b1, 1'b0, 4'b0001, 32'h00000080, 4};
    vecs[4]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 1'b0, 4'b0111, 32'h80ADBEEF, 4};
    vecs[5]  = '{1'b1, 3'b001, 32'h22, 32'h00001234, 1'b1, 1'b0, 4'b0011, 32'h0,        5};
    vecs[6]  = '{1'b0, 3'b010, 32'h20, 32'h0,        1'b1, 1'b0, 4'b0111, 32'h12345678, 4};
    vecs[7]  = '{1'b0, 3'b001, 32'h21, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        2};
    vecs[8]  = '{1'b1, 3'b010, 32'h06, 32'hDEADBEEF, 1'b0, 1'b1, 4'b0000, 32'h0,        2};
    vecs[9]  = '{1'b0, 3'b101, 32'h12, 32'h0,        1'b1, 1'b0, 4'b0011, 32'h000080AD, 4};
    vecs[10] = '{1'b0, 3'b001, 32'h12, 32'h0,        1'b1, 1'b0, 4'b1011, 32'hFFFF80AD, 4};
    vecs[11] = '{1'b0, 3'b011, 32'h10, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        2};
    vecs[12] = '{1'b1, 3'b011, 32'h10, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        2};
    vecs[13] = '{1'b0, 3'b010, 32'h11, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        2};
    vecs[14] = '{1'b0, 3'b010, 32'h12, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        2};
    vecs[15] = '{1'b1, 3'b100, 32'h10, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        2};
    v_to     = '{1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 1'b1, 1'b1, 4'b0111, 32'h0,       19};
    v_ld30   = '{1'b0, 3'b010, 32'h30, 32'h0,        1'b1, 1'b0, 4'b0111, 32'hCAFEF00D, 4};

    rst_n = 1'b0; preload = 1'b1; stall_en = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_memread", 32'(mem_memread), 32'd0);
    chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_mem_mask", 32'(mem_sign_mask), 32'd0);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_req(vecs[i], $sformatf("v%0d", i));

    stall_en = 1'b0;
    run_req(v_to, "store_timeout");
    stall_en = 1'b1;
    run_req(v_ld30, "load_after_timeout");

    // Reset asserted while a load sits in WAIT.
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_memread_before", 32'(mem_memread), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_memread", 32'(mem_memread), 32'd0);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_ready_after", 32'(req_ready), 32'd1);
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    chk("rstmid_dropped_resp", 32'(stray), 32'd0);
    run_req(vecs[4], "lw_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
